// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-5 stream demultiplexer.
package demux_pkg;

  localparam int unsigned CH_NUM    = 5;
  localparam logic [2:0]  SEL_BCAST = 3'd5;

  // Encoding of the sel input: direct channel, broadcast, or discard.
  typedef enum logic [2:0] {
    CH0   = 3'd0,
    CH1   = 3'd1,
    CH2   = 3'd2,
    CH3   = 3'd3,
    CH4   = 3'd4,
    BCAST = 3'd5,
    DROP6 = 3'd6,
    DROP7 = 3'd7
  } route_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single consumer channel.
// The top only raises load when free is high, so a load never overwrites a
// sample that the consumer has not taken yet.
module demux_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             free,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Slot can take a new sample if empty or being drained this cycle.
  assign free  = !valid_q || ready;
  assign dout  = data_q;
  assign valid = valid_q;

  // Load wins over drain so a simultaneous drain+load causes no bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register; data holds while stalled or after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/demux_1to5_stream.sv
// Routes one valid/ready sample stream to one of five channels, to all of
// them (broadcast), or to a sink that counts discarded samples.
module demux_1to5_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              sel,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CH_NUM*WIDTH-1:0] m_data,
  output logic [CH_NUM-1:0]       m_valid,
  input  logic [CH_NUM-1:0]       m_ready,
  output logic [CNT_W-1:0]        drop_cnt
);

  route_e            route;
  logic [CH_NUM-1:0] free;
  logic [CH_NUM-1:0] load;
  logic              accept;
  logic              drop;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign route  = route_e'(sel);
  assign accept = s_valid && s_ready;

  // Ready depends only on sel and the free state of the targeted slot(s).
  always_comb begin
    s_ready = 1'b0;
    drop    = 1'b0;
    case (route)
      CH0, CH1, CH2, CH3, CH4: s_ready = free[sel];
      BCAST:                   s_ready = &free;
      default: begin
        s_ready = 1'b1;
        drop    = accept;
      end
    endcase
  end

  // sel is only looked at in the accept cycle via the load strobes.
  for (genvar n = 0; n < CH_NUM; n++) begin : g_slot
    assign load[n] = accept && ((sel == 3'(n)) || (sel == SEL_BCAST));

    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[n]),
      .din   (s_data),
      .ready (m_ready[n]),
      .free  (free[n]),
      .dout  (m_data[n*WIDTH +: WIDTH]),
      .valid (m_valid[n])
    );
  end

  // Saturating count of discarded samples.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1to5_stream.sv
// Directed bench for demux_1to5_stream, plus a narrow-counter instance for
// saturation.
module tb_demux_1to5_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [39:0] m_data;
  logic [4:0]  m_valid;
  logic [4:0]  m_ready;
  logic [15:0] drop_cnt;

  logic [2:0]  sat_sel;
  logic [7:0]  sat_data;
  logic        sat_valid;
  logic        sat_ready;
  logic [39:0] sat_mdata;
  logic [4:0]  sat_mvalid;
  logic [4:0]  sat_mready;
  logic [3:0]  sat_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1to5_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .drop_cnt(drop_cnt)
  );

  demux_1to5_stream #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .sel(sat_sel), .s_data(sat_data), .s_valid(sat_valid),
    .s_ready(sat_ready), .m_data(sat_mdata), .m_valid(sat_mvalid), .m_ready(sat_mready),
    .drop_cnt(sat_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 3'd2; s_data = 8'h5A; s_valid = 1'b1; m_ready = 5'h00;
    sat_sel = 3'd6; sat_data = 8'h00; sat_valid = 1'b0; sat_mready = 5'h1f;
    tick(); tick();
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL reset_m_valid got %h want 00", m_valid); end
    checks++;
    if (m_data !== 40'h0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
    checks++;
    if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_route();
    m_ready = 5'h1f; sel = 3'd3; s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 5'b01000) begin errors++; $display("FAIL route_valid got %b want 01000", m_valid); end
    checks++;
    if (m_data !== 40'h00_A5_00_00_00) begin errors++; $display("FAIL route_data got %h want 00a5000000", m_data); end
    tick();
    checks++;
    if (m_valid !== 5'b00000) begin errors++; $display("FAIL route_drain got %b want 00000", m_valid); end
    checks++;
    if (m_data[24 +: 8] !== 8'hA5) begin errors++; $display("FAIL route_hold got %h want a5", m_data[24 +: 8]); end
  endtask

  task automatic test_stall();
    m_ready = 5'h00; sel = 3'd1; s_data = 8'h11; s_valid = 1'b1;
    tick();
    s_data = 8'h22;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready got %b want 0", s_ready); end
    tick();
    checks++;
    if (m_data[8 +: 8] !== 8'h11 || m_valid[1] !== 1'b1) begin
      errors++; $display("FAIL stall_hold got %h/%b want 11/1", m_data[8 +: 8], m_valid[1]);
    end
    m_ready = 5'b00010;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_data[8 +: 8] !== 8'h22 || m_valid[1] !== 1'b1) begin
      errors++; $display("FAIL stall_next got %h/%b want 22/1", m_data[8 +: 8], m_valid[1]);
    end
    tick();
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL stall_drain got %b want 00000", m_valid); end
  endtask

  task automatic test_bcast();
    m_ready = 5'b01111; sel = 3'd4; s_data = 8'h44; s_valid = 1'b1;
    tick();
    sel = 3'd5; s_data = 8'h55;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL bcast_blocked got %b want 0", s_ready); end
    tick();
    checks++;
    if (m_valid !== 5'b10000 || m_data[32 +: 8] !== 8'h44) begin
      errors++; $display("FAIL bcast_wait got %b/%h want 10000/44", m_valid, m_data[32 +: 8]);
    end
    m_ready = 5'h1f;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 5'h1f || m_data !== 40'h55_55_55_55_55) begin
      errors++; $display("FAIL bcast_all got %b/%h want 11111/5555555555", m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL bcast_drain got %b want 00000", m_valid); end
  endtask

  task automatic test_drop();
    m_ready = 5'h00; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel = (i < 5) ? 3'd6 : 3'd7;
      s_data = 8'(8'hC0 + i);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL drop_ready i=%0d got %b want 1", i, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'd10) begin errors++; $display("FAIL drop_cnt got %0d want 10", drop_cnt); end
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL drop_m_valid got %b want 00000", m_valid); end
    // Narrow counter saturates at 15.
    sat_valid = 1'b1; sat_sel = 3'd6;
    for (int i = 0; i < 20; i++) begin
      sat_data = 8'(i);
      tick();
      if (i == 14) begin
        checks++;
        if (sat_drop !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d want 15", sat_drop); end
      end
    end
    sat_valid = 1'b0;
    checks++;
    if (sat_drop !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", sat_drop); end
    checks++;
    if (sat_mvalid !== 5'h00) begin errors++; $display("FAIL sat_m_valid got %b want 00000", sat_mvalid); end
  endtask

  task automatic test_back_to_back();
    m_ready = 5'h1f; sel = 3'd0; s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(8'h10 + i);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got %b want 1", i, s_ready); end
      tick();
      checks++;
      if (m_valid !== 5'b00001 || m_data[7:0] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL b2b_data i=%0d got %b/%h want 00001/%h", i, m_valid, m_data[7:0], 8'(8'h10 + i));
      end
    end
    // Asynchronous reset mid-cycle, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL areset_valid got %b want 00000", m_valid); end
    checks++;
    if (m_data !== 40'h0) begin errors++; $display("FAIL areset_data got %h want 0", m_data); end
    checks++;
    if (drop_cnt !== 16'h0 || sat_drop !== 4'h0) begin
      errors++; $display("FAIL areset_cnt got %0d/%0d want 0/0", drop_cnt, sat_drop);
    end
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (m_valid !== 5'h00) begin errors++; $display("FAIL post_reset_valid got %b want 00000", m_valid); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall();
    test_bcast();
    test_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
